// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared mode constants, defaults and pointer sizing for the sync FIFO
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  localparam int DEFAULT_AE_THRESH = 2;
  localparam int DEFAULT_AF_MARGIN = 2;

  // One extra MSB beyond the address bits tells full apart from empty
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - WIDTH x DEPTH register array, synchronous write, asynchronous read
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately left unreset; pointers alone define valid contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with FWFT option, occupancy count,
// programmable almost flags and one-cycle overflow/underflow pulses
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - DEFAULT_AF_MARGIN,
  parameter int AE_THRESH = DEFAULT_AE_THRESH,
  parameter int FWFT      = FIFO_STD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       datain,
  output logic [WIDTH-1:0]       dataout,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] AF_C = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C = PW'(AE_THRESH);

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_sync_param: WIDTH must be >= 1");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 4");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("fifo_sync_param: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("fifo_sync_param: AE_THRESH must be in 0..DEPTH-1");
  end
  if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
    $error("fifo_sync_param: FWFT must be 0 or 1");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full_w, empty_w;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_data;

  // Equal pointers mean empty; same address with differing lap bit means full
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_acc = wr_en && !full_w;
  assign rd_acc = rd_en && !empty_w;

  always_comb begin
    wr_ptr_d    = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d  = wr_en && full_w;
    underflow_d = rd_en && empty_w;
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (datain),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign dataout = empty_w ? '0 : rd_data;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = rd_acc ? rd_data : dout_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign dataout = dout_q;
  end

  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed and random checks of fifo_sync_param in standard,
// FWFT and custom-threshold configurations against queue scoreboards
module tb_fifo_sync_param;

  logic clk;
  logic rst;

  logic       s_wr, s_rd, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [7:0] s_din, s_dout;
  logic [4:0] s_count;

  logic       f_wr, f_rd, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [7:0] f_din, f_dout;
  logic [4:0] f_count;

  logic       t_wr, t_rd, t_full, t_empty, t_af, t_ae, t_ovf, t_unf;
  logic [7:0] t_din, t_dout;
  logic [4:0] t_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_s[$];
  logic [7:0] q_f[$];
  logic [7:0] q_t[$];
  logic [7:0] dout_s;

  fifo_sync_param #(.WIDTH(8), .DEPTH(16)) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr), .rd_en(s_rd), .datain(s_din), .dataout(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr), .rd_en(f_rd), .datain(f_din), .dataout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(3)) u_thr (
    .clk(clk), .rst(rst), .wr_en(t_wr), .rd_en(t_rd), .datain(t_din), .dataout(t_dout),
    .full(t_full), .empty(t_empty), .almost_full(t_af), .almost_empty(t_ae),
    .count(t_count), .overflow(t_ovf), .underflow(t_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic std_op(input logic w, input logic r, input logic [7:0] d);
    logic full_m, empty_m;
    full_m  = (q_s.size() == 16);
    empty_m = (q_s.size() == 0);
    if (r && !empty_m) dout_s = q_s.pop_front();
    if (w && !full_m) q_s.push_back(d);
    s_wr = w; s_rd = r; s_din = d;
    @(posedge clk); #1;
    s_wr = 1'b0; s_rd = 1'b0;
    chk("std_count", 32'(s_count), 32'(q_s.size()));
    chk("std_dout", 32'(s_dout), 32'(dout_s));
    chk("std_overflow", 32'(s_ovf), 32'(w && full_m));
    chk("std_underflow", 32'(s_unf), 32'(r && empty_m));
    chk("std_flags", 32'({s_full, s_empty, s_af, s_ae}),
        32'({q_s.size() == 16, q_s.size() == 0, q_s.size() >= 14, q_s.size() <= 2}));
  endtask

  task automatic fw_op(input logic w, input logic r, input logic [7:0] d);
    logic full_m, empty_m;
    full_m  = (q_f.size() == 16);
    empty_m = (q_f.size() == 0);
    if (r && !empty_m) void'(q_f.pop_front());
    if (w && !full_m) q_f.push_back(d);
    f_wr = w; f_rd = r; f_din = d;
    @(posedge clk); #1;
    f_wr = 1'b0; f_rd = 1'b0;
    chk("fwft_count", 32'(f_count), 32'(q_f.size()));
    chk("fwft_dout", 32'(f_dout), (q_f.size() > 0) ? 32'(q_f[0]) : 32'h0);
    chk("fwft_empty", 32'(f_empty), 32'(q_f.size() == 0));
    chk("fwft_underflow", 32'(f_unf), 32'(r && empty_m));
  endtask

  task automatic thr_op(input logic w, input logic r, input logic [7:0] d);
    if (r && q_t.size() > 0) void'(q_t.pop_front());
    if (w && q_t.size() < 16) q_t.push_back(d);
    t_wr = w; t_rd = r; t_din = d;
    @(posedge clk); #1;
    t_wr = 1'b0; t_rd = 1'b0;
    chk("thr_count", 32'(t_count), 32'(q_t.size()));
    chk("thr_flags", 32'({t_full, t_empty, t_af, t_ae}),
        32'({q_t.size() == 16, q_t.size() == 0, q_t.size() >= 12, q_t.size() <= 3}));
  endtask

  initial begin
    logic       rw, rr;
    logic [7:0] rd8;
    s_wr = 0; s_rd = 0; s_din = 0;
    f_wr = 0; f_rd = 0; f_din = 0;
    t_wr = 0; t_rd = 0; t_din = 0;
    dout_s = 8'h00;
    rst = 1'b0;
    #3;
    chk("reset_count", 32'(s_count), 32'd0);
    chk("reset_flags", 32'({s_full, s_empty, s_af, s_ae}), 32'b0101);
    chk("reset_dout", 32'(s_dout), 32'h0);
    chk("reset_pulses", 32'({s_ovf, s_unf}), 32'b00);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Mid-stream asynchronous reset discards everything in flight
    for (int i = 0; i < 5; i++) std_op(1'b1, 1'b0, 8'(8'h31 + i));
    std_op(1'b0, 1'b1, 8'h00);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(s_count), 32'd0);
    chk("async_rst_flags", 32'({s_empty, s_ae}), 32'b11);
    chk("async_rst_dout", 32'(s_dout), 32'h0);
    q_s.delete();
    dout_s = 8'h00;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    std_op(1'b0, 1'b1, 8'h00);
    std_op(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 16; i++) std_op(1'b1, 1'b0, 8'(i));
    std_op(1'b1, 1'b0, 8'hEE);
    for (int i = 0; i < 16; i++) std_op(1'b0, 1'b1, 8'h00);

    std_op(1'b1, 1'b1, 8'h11);
    std_op(1'b1, 1'b1, 8'h07);
    std_op(1'b1, 1'b1, 8'h05);
    std_op(1'b1, 1'b1, 8'h64);
    std_op(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 120; i++) begin
      rw  = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      rd8 = 8'($urandom_range(0, 255));
      std_op(rw, rr, rd8);
    end

    fw_op(1'b1, 1'b0, 8'hA5);
    fw_op(1'b0, 1'b0, 8'h00);
    fw_op(1'b0, 1'b1, 8'h00);
    fw_op(1'b0, 1'b1, 8'h00);
    fw_op(1'b1, 1'b0, 8'h3C);
    fw_op(1'b1, 1'b1, 8'h5A);
    fw_op(1'b1, 1'b0, 8'hC3);
    fw_op(1'b0, 1'b1, 8'h00);
    fw_op(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 16; i++) thr_op(1'b1, 1'b0, 8'(i));
    thr_op(1'b1, 1'b0, 8'hFF);
    chk("thr_overflow", 32'(t_ovf), 32'd1);
    for (int i = 0; i < 16; i++) thr_op(1'b0, 1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
